// File: rtl/mmio_bus_master.sv
// CPU-to-device MMIO bridge: SETUP/ACCESS/DONE strobe sequencing, address window decode, irq path.
// Optional MMIO_INTR_SYNC_EN: synchronised, sticky, clearable irq instead of a combinational pass-through.
module mmio_bus_master #(
    parameter logic [19:0] BASE_HI = 20'hFFFF2,
    parameter int          WR_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic        cpu_busy,
    output logic        dev_cs_n,
    output logic        dev_rd_n,
    output logic        dev_wr_n,
    output logic [11:0] dev_addr,
    output logic [31:0] dev_wdata,
    input  logic [31:0] dev_rdata,
    input  logic        dev_intr_n,
    output logic        irq,
    input  logic        irq_clr
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

    state_t     state;
    logic       we_q;
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            cnt       <= 4'd0;
            dev_cs_n  <= 1'b1;
            dev_rd_n  <= 1'b1;
            dev_wr_n  <= 1'b1;
            dev_addr  <= 12'd0;
            dev_wdata <= 32'd0;
            cpu_rdata <= 32'd0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        we_q     <= cpu_we;
                        cpu_busy <= 1'b1;
                        if (cpu_addr[31:12] == BASE_HI) begin
                            state     <= SETUP;
                            dev_cs_n  <= 1'b0;
                            dev_addr  <= cpu_addr[11:0];
                            dev_wdata <= cpu_wdata;
                        end else begin
                            // Outside the window: complete immediately, never touch the device.
                            state     <= DONE;
                            cpu_ack   <= 1'b1;
                            cpu_err   <= 1'b1;
                            cpu_rdata <= 32'd0;
                        end
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                    cnt   <= WR_CNT;
                    if (we_q) dev_wr_n <= 1'b0;
                    else      dev_rd_n <= 1'b0;
                end
                ACCESS: begin
                    if (!we_q) begin
                        // Capture on the same edge the device sees the read, so read-to-clear is safe.
                        cpu_rdata <= dev_rdata;
                        dev_rd_n  <= 1'b1;
                        dev_cs_n  <= 1'b1;
                        cpu_ack   <= 1'b1;
                        state     <= DONE;
                    end else if (cnt == 4'd0) begin
                        dev_wr_n <= 1'b1;
                        dev_cs_n <= 1'b1;
                        cpu_ack  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    cpu_ack  <= 1'b0;
                    cpu_err  <= 1'b0;
                    cpu_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MMIO_INTR_SYNC_EN
    // [0],[1] synchronise; [2] is the previous synchronised value for falling-edge detect.
    logic [2:0] intr_sync;
    logic       irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            intr_sync <= 3'b111;
            irq_q     <= 1'b0;
        end else begin
            intr_sync <= {intr_sync[1:0], dev_intr_n};
            if (intr_sync[2] && !intr_sync[1]) irq_q <= 1'b1;
            else if (irq_clr)                  irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq = ~dev_intr_n;
`endif
endmodule
